reg_mask_scanner: RTL and testbench

- Parametrised, sequential successor to the 32:5 one-hot encoder.
- Accepts a multi-hot register mask, e.g. a load/store-multiple register list or the bus-select vector.
- Emits the binary index of every set bit, one per handshake, in a fixed priority order.
- Sits between the control unit and the register-file select decoder; the control unit stalls via out_ready.

---
 rtl/reg_mask_scanner.sv | 103 ++++++++++
 tb/tb_reg_mask_scanner.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_mask_scanner.sv
// Sequential multi-hot mask scanner: emits the index of each set bit of a captured
// mask, one per valid/ready handshake, in LSB-first or MSB-first priority order.
module reg_mask_scanner #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned IDX_W     = $clog2(WIDTH),
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] mask_in,
  input  logic             abort,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] code,
  output logic             last,
  output logic [IDX_W:0]   remaining,
  output logic             done
);

  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state;
  logic [WIDTH-1:0]   pending;
  logic               done_q;
  logic [IDX_W-1:0]   sel;
  logic [CNT_W-1:0]   cnt;

  // Priority select over pending; the last match in loop order wins.
  always_comb begin
    sel = '0;
    if (LSB_FIRST) begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (pending[i]) sel = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (pending[i]) sel = IDX_W'(i);
      end
    end
  end

  // Popcount of pending; needs IDX_W+1 bits so an all-ones mask fits.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt = cnt + CNT_W'(pending[i]);
    end
  end

  // Pending is kept at zero whenever the FSM is idle, so code/last/remaining read 0 there.
  assign busy      = (state == SCAN);
  assign out_valid = (state == SCAN);
  assign code      = sel;
  assign last      = (cnt == CNT_W'(1));
  assign remaining = cnt;
  assign done      = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (load && !abort) begin
            if (mask_in != '0) begin
              pending <= mask_in;
              state   <= SCAN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        SCAN: begin
          // Abort wins over a coincident handshake and never raises done.
          if (abort) begin
            pending <= '0;
            state   <= IDLE;
          end else if (out_ready) begin
            if (last) begin
              pending <= '0;
              state   <= IDLE;
              done_q  <= 1'b1;
            end else begin
              pending <= pending & ~(WIDTH'(1) << sel);
            end
          end
        end
        default: begin
          pending <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_mask_scanner.sv
// Directed bench for reg_mask_scanner: vector table on the default instance plus
// hand-written full-mask, async-reset and 8-bit parameter sequences.
module tb_reg_mask_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance a: WIDTH=32, LSB first
  logic        load_a = 0, abort_a = 0, ready_a = 0;
  logic [31:0] mask_a = '0;
  logic        busy_a, valid_a, last_a, done_a;
  logic [4:0]  code_a;
  logic [5:0]  rem_a;

  reg_mask_scanner #(.WIDTH(32), .LSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst), .load(load_a), .mask_in(mask_a), .abort(abort_a),
    .busy(busy_a), .out_valid(valid_a), .out_ready(ready_a), .code(code_a),
    .last(last_a), .remaining(rem_a), .done(done_a));

  // Instance m: WIDTH=32, MSB first
  logic        load_m = 0, abort_m = 0, ready_m = 0;
  logic [31:0] mask_m = '0;
  logic        busy_m, valid_m, last_m, done_m;
  logic [4:0]  code_m;
  logic [5:0]  rem_m;

  reg_mask_scanner #(.WIDTH(32), .LSB_FIRST(1'b0)) u_m (
    .clk(clk), .rst(rst), .load(load_m), .mask_in(mask_m), .abort(abort_m),
    .busy(busy_m), .out_valid(valid_m), .out_ready(ready_m), .code(code_m),
    .last(last_m), .remaining(rem_m), .done(done_m));

  // Instances l8 / h8: WIDTH=8, both orders, shared stimulus
  logic       load_8 = 0, abort_8 = 0, ready_8 = 0;
  logic [7:0] mask_8 = '0;
  logic       busy_l, valid_l, last_l, done_l, busy_h, valid_h, last_h, done_h;
  logic [2:0] code_l, code_h;
  logic [3:0] rem_l, rem_h;

  reg_mask_scanner #(.WIDTH(8), .IDX_W(3), .LSB_FIRST(1'b1)) u_l8 (
    .clk(clk), .rst(rst), .load(load_8), .mask_in(mask_8), .abort(abort_8),
    .busy(busy_l), .out_valid(valid_l), .out_ready(ready_8), .code(code_l),
    .last(last_l), .remaining(rem_l), .done(done_l));

  reg_mask_scanner #(.WIDTH(8), .IDX_W(3), .LSB_FIRST(1'b0)) u_h8 (
    .clk(clk), .rst(rst), .load(load_8), .mask_in(mask_8), .abort(abort_8),
    .busy(busy_h), .out_valid(valid_h), .out_ready(ready_8), .code(code_h),
    .last(last_h), .remaining(rem_h), .done(done_h));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Outputs are checked first (state before the edge), then inputs are applied.
  typedef struct {
    logic        load;
    logic [31:0] mask;
    logic        ready;
    logic        abort;
    logic        valid;
    logic [4:0]  code;
    logic        last;
    logic [5:0]  rem;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic ld, input logic [31:0] m, input logic rdy,
                             input logic ab, input logic vl, input int cd,
                             input logic ls, input int rm, input logic dn);
    vec_t r;
    r.load = ld; r.mask = m; r.ready = rdy; r.abort = ab;
    r.valid = vl; r.code = 5'(cd); r.last = ls; r.rem = 6'(rm); r.done = dn;
    return r;
  endfunction

  initial begin
    // Sparse mask
    vecs.push_back(v(1, 32'h8000_0001, 1, 0,  0,  0, 0, 0, 0));
    vecs.push_back(v(0, 32'h0,         1, 0,  1,  0, 0, 2, 0));
    vecs.push_back(v(0, 32'h0,         1, 0,  1, 31, 1, 1, 0));
    vecs.push_back(v(0, 32'h0,         1, 0,  0,  0, 0, 0, 1));
    // Stall for five cycles, one handshake, then abort with ready
    vecs.push_back(v(1, 32'h0000_0F00, 0, 0,  0,  0, 0, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(v(0, 32'h0, 0, 0, 1, 8, 0, 4, 0));
    vecs.push_back(v(0, 32'h0,         1, 0,  1,  8, 0, 4, 0));
    vecs.push_back(v(0, 32'h0,         1, 1,  1,  9, 0, 3, 0));
    vecs.push_back(v(0, 32'h0,         0, 0,  0,  0, 0, 0, 0));
    vecs.push_back(v(0, 32'h0,         0, 0,  0,  0, 0, 0, 0));
    // Empty mask, then load ignored while busy
    vecs.push_back(v(1, 32'h0,         1, 0,  0,  0, 0, 0, 0));
    vecs.push_back(v(0, 32'h0,         1, 0,  0,  0, 0, 0, 1));
    vecs.push_back(v(1, 32'h10,        0, 0,  0,  0, 0, 0, 0));
    vecs.push_back(v(1, 32'hFF,        0, 0,  1,  4, 1, 1, 0));
    vecs.push_back(v(0, 32'h0,         1, 0,  1,  4, 1, 1, 0));
    // Load accepted in the same cycle done is high
    vecs.push_back(v(1, 32'h3,         1, 0,  0,  0, 0, 0, 1));
    vecs.push_back(v(0, 32'h0,         1, 0,  1,  0, 0, 2, 0));
    vecs.push_back(v(0, 32'h0,         1, 0,  1,  1, 1, 1, 0));
    // Abort together with load in idle suppresses the load
    vecs.push_back(v(1, 32'h5,         1, 1,  0,  0, 0, 0, 1));
    vecs.push_back(v(0, 32'h0,         0, 0,  0,  0, 0, 0, 0));
    // Abort during a stall
    vecs.push_back(v(1, 32'h6,         0, 0,  0,  0, 0, 0, 0));
    vecs.push_back(v(0, 32'h0,         0, 1,  1,  1, 0, 2, 0));
    vecs.push_back(v(0, 32'h0,         0, 0,  0,  0, 0, 0, 0));
    vecs.push_back(v(0, 32'h0,         0, 0,  0,  0, 0, 0, 0));
  end

  int exp_codes_l[3] = '{2, 5, 7};
  int exp_codes_h[3] = '{7, 5, 2};

  initial begin
    // Reset state
    #2;
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_code", code_a, 0);
    chk("rst_last", last_a, 0);
    chk("rst_rem", rem_a, 0);
    chk("rst_done", done_a, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors on instance a
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), valid_a, vecs[i].valid);
      chk($sformatf("vec%0d_busy", i), busy_a, vecs[i].valid);
      chk($sformatf("vec%0d_code", i), code_a, vecs[i].code);
      chk($sformatf("vec%0d_last", i), last_a, vecs[i].last);
      chk($sformatf("vec%0d_rem", i), rem_a, vecs[i].rem);
      chk($sformatf("vec%0d_done", i), done_a, vecs[i].done);
      load_a = vecs[i].load; mask_a = vecs[i].mask;
      ready_a = vecs[i].ready; abort_a = vecs[i].abort;
    end

    // Full mask back-to-back, both orders
    @(negedge clk);
    load_a = 1; mask_a = 32'hFFFF_FFFF; ready_a = 1; abort_a = 0;
    load_m = 1; mask_m = 32'hFFFF_FFFF; ready_m = 1; abort_m = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      load_a = 0; load_m = 0;
      chk($sformatf("full_lsb_code%0d", k), code_a, k);
      chk($sformatf("full_lsb_rem%0d", k), rem_a, 32 - k);
      chk($sformatf("full_lsb_last%0d", k), last_a, (k == 31));
      chk($sformatf("full_lsb_done%0d", k), done_a, 0);
      chk($sformatf("full_msb_code%0d", k), code_m, 31 - k);
      chk($sformatf("full_msb_rem%0d", k), rem_m, 32 - k);
      chk($sformatf("full_msb_last%0d", k), last_m, (k == 31));
    end
    @(negedge clk);
    chk("full_lsb_done", done_a, 1);
    chk("full_lsb_idle", valid_a, 0);
    chk("full_msb_done", done_m, 1);
    @(negedge clk);
    chk("full_lsb_done_end", done_a, 0);
    chk("full_msb_done_end", done_m, 0);

    // Async reset mid-scan after the second handshake
    load_a = 1; mask_a = 32'h0000_00F0; ready_a = 1;
    @(negedge clk);
    load_a = 0;
    chk("ar_code0", code_a, 4);
    @(negedge clk);
    chk("ar_code1", code_a, 5);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_busy", busy_a, 0);
    chk("ar_valid", valid_a, 0);
    chk("ar_code", code_a, 0);
    chk("ar_last", last_a, 0);
    chk("ar_rem", rem_a, 0);
    chk("ar_done", done_a, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ar_post_valid", valid_a, 0);
    load_a = 1; mask_a = 32'h1;
    @(negedge clk);
    load_a = 0;
    chk("ar_new_code", code_a, 0);
    chk("ar_new_last", last_a, 1);
    chk("ar_new_rem", rem_a, 1);
    @(negedge clk);
    chk("ar_new_done", done_a, 1);

    // WIDTH=8 sweep, both orders
    load_8 = 1; mask_8 = 8'b1010_0100; ready_8 = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      load_8 = 0;
      chk($sformatf("w8_lsb_code%0d", k), code_l, exp_codes_l[k]);
      chk($sformatf("w8_msb_code%0d", k), code_h, exp_codes_h[k]);
      chk($sformatf("w8_lsb_rem%0d", k), rem_l, 3 - k);
      chk($sformatf("w8_msb_rem%0d", k), rem_h, 3 - k);
      chk($sformatf("w8_lsb_last%0d", k), last_l, (k == 2));
      chk($sformatf("w8_msb_valid%0d", k), valid_h, 1);
    end
    @(negedge clk);
    chk("w8_lsb_done", done_l, 1);
    chk("w8_msb_done", done_h, 1);
    chk("w8_lsb_busy", busy_l, 0);
    chk("w8_msb_busy", busy_h, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
